// File: rtl/opb_bus_arbiter.sv
// Two-master OPB decode-bus arbiter: issue/complete sequencing with one-cycle ACK per access.
// Round-robin contention resolution when OPB_ARB_RR_EN is defined, fixed A-priority otherwise.
module opb_bus_arbiter #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        A_REQ,
  input  logic        A_RNW,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_WDATA,
  output logic        A_ACK,
  output logic [31:0] A_RDATA,
  input  logic        B_REQ,
  input  logic        B_RNW,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_WDATA,
  output logic        B_ACK,
  output logic [31:0] B_RDATA,
  output logic        DEC_RE,
  output logic        DEC_WE,
  output logic [31:0] DEC_ADDR,
  output logic [31:0] DEC_DI,
  input  logic [31:0] DEC_DO,
  output logic        BUSY,
  output logic        GRANT_B
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_ACK, S_GAP} state_t;

  // GAP lasts GAP_CYCLES cycles: counter loads N-1 on leaving ACK and exits at zero.
  localparam logic [3:0] GAP_LD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t      state_q, state_d;
  logic        rnw_q, rnw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_b_q, grant_b_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic [3:0]  gap_q, gap_d;
  logic        pick_b;
  logic        any_req;

`ifdef OPB_ARB_RR_EN
  logic last_b_q, last_b_d;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) last_b_q <= 1'b1;
    else         last_b_q <= last_b_d;
  end

  always_comb begin
    pick_b   = B_REQ && (!A_REQ || !last_b_q);
    last_b_d = last_b_q;
    if (state_q == S_IDLE && (A_REQ || B_REQ)) last_b_d = pick_b;
  end
`else
  always_comb pick_b = B_REQ && !A_REQ;
`endif

  assign any_req = A_REQ || B_REQ;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q   <= S_IDLE;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant_b_q <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      grant_b_q <= grant_b_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req) state_d = S_ISSUE;
      S_ISSUE:   state_d = rnw_q ? S_RD_WAIT : S_ACK;
      S_RD_WAIT: state_d = S_ACK;
      S_ACK:     state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:     if (gap_q == 4'd0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_b_d = grant_b_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        rnw_d     = pick_b ? B_RNW   : A_RNW;
        addr_d    = pick_b ? B_ADDR  : A_ADDR;
        wdata_d   = pick_b ? B_WDATA : A_WDATA;
        grant_b_d = pick_b;
      end
      // Writes present zero read data during their ACK; only the winner's register moves.
      S_ISSUE: if (!rnw_q) begin
        if (grant_b_q) b_rdata_d = '0;
        else           a_rdata_d = '0;
      end
      S_RD_WAIT: begin
        if (grant_b_q) b_rdata_d = DEC_DO;
        else           a_rdata_d = DEC_DO;
      end
      S_ACK:   gap_d = GAP_LD;
      S_GAP:   if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
      default: ;
    endcase
  end

  always_comb begin
    DEC_RE   = (state_q == S_ISSUE) &&  rnw_q;
    DEC_WE   = (state_q == S_ISSUE) && !rnw_q;
    DEC_ADDR = (state_q == S_ISSUE) ? addr_q : '0;
    DEC_DI   = DEC_WE ? wdata_q : '0;
    A_ACK    = (state_q == S_ACK) && !grant_b_q;
    B_ACK    = (state_q == S_ACK) &&  grant_b_q;
    A_RDATA  = a_rdata_q;
    B_RDATA  = b_rdata_q;
    BUSY     = (state_q != S_IDLE);
    GRANT_B  = grant_b_q;
  end

endmodule

// File: tb/tb_opb_bus_arbiter.sv
// Directed bench for opb_bus_arbiter: one instance with no gap, one with a 3-cycle gap.
module tb_opb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_rnw = 1'b0, b_req = 1'b0, b_rnw = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;

  logic        a_ack, b_ack, dec_re, dec_we, busy, grant_b;
  logic [31:0] a_rdata, b_rdata, dec_addr, dec_di;
  logic [31:0] dec_do = '0;

  logic        g_a_ack, g_b_ack, g_dec_re, g_dec_we, g_busy, g_grant_b;
  logic [31:0] g_a_rdata, g_b_rdata, g_dec_addr, g_dec_di;
  logic [31:0] g_dec_do = '0;

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;

  always #5 clk = ~clk;

  opb_bus_arbiter #(.GAP_CYCLES(0)) u_dut (
    .OPB_CLK(clk), .OPB_RST(rst),
    .A_REQ(a_req), .A_RNW(a_rnw), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(a_ack), .A_RDATA(a_rdata),
    .B_REQ(b_req), .B_RNW(b_rnw), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(b_ack), .B_RDATA(b_rdata),
    .DEC_RE(dec_re), .DEC_WE(dec_we), .DEC_ADDR(dec_addr), .DEC_DI(dec_di),
    .DEC_DO(dec_do), .BUSY(busy), .GRANT_B(grant_b)
  );

  opb_bus_arbiter #(.GAP_CYCLES(3)) u_gap (
    .OPB_CLK(clk), .OPB_RST(rst),
    .A_REQ(a_req), .A_RNW(a_rnw), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .A_ACK(g_a_ack), .A_RDATA(g_a_rdata),
    .B_REQ(b_req), .B_RNW(b_rnw), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .B_ACK(g_b_ack), .B_RDATA(g_b_rdata),
    .DEC_RE(g_dec_re), .DEC_WE(g_dec_we), .DEC_ADDR(g_dec_addr), .DEC_DI(g_dec_di),
    .DEC_DO(g_dec_do), .BUSY(g_busy), .GRANT_B(g_grant_b)
  );

  // Peripheral stand-in: registered read data one cycle after DEC_RE.
  function automatic logic [31:0] periph(input logic [31:0] a);
    return (a == 32'h80) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    if (dec_re)   dec_do   <= periph(dec_addr);
    if (g_dec_re) g_dec_do <= periph(g_dec_addr);
  end

  always @(negedge clk)
    if (!rst && ((dec_re && dec_we) || (a_ack && b_ack) || (g_a_ack && g_b_ack))) viol++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks;
    int pulses;
    int t0;
    int t1;
    logic exp_b;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_dec",     32'({dec_re, dec_we}), 32'd0);
    chk("rst_acks",    32'({a_ack, b_ack}),   32'd0);
    chk("rst_grant_b", 32'(grant_b), 32'd0);
    chk("rst_addr",    dec_addr,     32'd0);
    rst = 1'b0;
    tick();

    // Single A write
    a_req = 1'b1; a_rnw = 1'b0; a_addr = 32'h40; a_wdata = 32'hDEAD_BEEF;
    tick();
    chk("aw_we",    32'(dec_we), 32'd1);
    chk("aw_re",    32'(dec_re), 32'd0);
    chk("aw_addr",  dec_addr,    32'h40);
    chk("aw_di",    dec_di,      32'hDEAD_BEEF);
    chk("aw_noack", 32'(a_ack),  32'd0);
    tick();
    chk("aw_ack",   32'(a_ack),  32'd1);
    chk("aw_back",  32'(b_ack),  32'd0);
    chk("aw_we2",   32'(dec_we), 32'd0);
    chk("aw_rdata", a_rdata,     32'd0);
    a_req = 1'b0;
    tick();
    chk("aw_idle",  32'(busy),   32'd0);

    // Single B read
    b_req = 1'b1; b_rnw = 1'b1; b_addr = 32'h80;
    tick();
    chk("br_re",    32'(dec_re),  32'd1);
    chk("br_addr",  dec_addr,     32'h80);
    chk("br_di",    dec_di,       32'd0);
    chk("br_grant", 32'(grant_b), 32'd1);
    tick();
    chk("br_wait_re",  32'(dec_re), 32'd0);
    chk("br_wait_ack", 32'(b_ack),  32'd0);
    tick();
    chk("br_ack",   32'(b_ack), 32'd1);
    chk("br_aack",  32'(a_ack), 32'd0);
    chk("br_rdata", b_rdata,    32'h1234_5678);
    chk("br_ardata_kept", a_rdata, 32'd0);
    b_req = 1'b0;
    repeat (3) tick();

    // Continuous contention, both reads
    a_req = 1'b1; a_rnw = 1'b1; a_addr = 32'h100;
    b_req = 1'b1; b_rnw = 1'b1; b_addr = 32'h200;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      tick();
      if (a_ack || b_ack) begin
`ifdef OPB_ARB_RR_EN
        exp_b = (acks % 2) == 1;
`else
        exp_b = 1'b0;
`endif
        chk("cont_winner", 32'(b_ack), 32'(exp_b));
        chk("cont_rdata", b_ack ? b_rdata : a_rdata, exp_b ? 32'hA5A5_0200 : 32'hA5A5_0100);
        acks++;
      end
    end
    chk("cont_count", 32'(acks), 32'd4);
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) tick();

    // Gap spacing on the GAP_CYCLES=3 instance
    a_req = 1'b1; a_rnw = 1'b0; a_addr = 32'h44; a_wdata = 32'h0000_00AA;
    pulses = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 40 && pulses < 2; c++) begin
      tick();
      if (g_dec_we) begin
        if (pulses == 0) t0 = c;
        else             t1 = c;
        pulses++;
      end
    end
    chk("gap_pulses",  32'(pulses),  32'd2);
    chk("gap_spacing", 32'(t1 - t0), 32'd6);
    a_req = 1'b0;
    repeat (10) tick();

    // Reset during RD_WAIT of an A read
    a_req = 1'b1; a_rnw = 1'b1; a_addr = 32'h300;
    tick();
    chk("rr_issue_re", 32'(dec_re), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rr_busy",  32'(busy),  32'd0);
    chk("rr_grant", 32'(grant_b), 32'd0);
    @(posedge clk); #1;
    chk("rr_noack", 32'(a_ack), 32'd0);
    chk("rr_rdata", a_rdata,    32'd0);
    rst = 1'b0;
    tick();
    chk("rr_fresh_re",   32'(dec_re), 32'd1);
    chk("rr_fresh_addr", dec_addr,    32'h300);
    repeat (2) tick();
    chk("rr_ack",       32'(a_ack), 32'd1);
    chk("rr_ack_rdata", a_rdata,    32'hA5A5_0300);
    a_req = 1'b0;
    repeat (3) tick();

    // A pulses one cycle while B owns the bus: withdrawn, never granted
    b_req = 1'b1; b_rnw = 1'b1; b_addr = 32'h80;
    tick();
    chk("wd_grant_b", 32'(grant_b), 32'd1);
    a_req = 1'b1; a_rnw = 1'b1; a_addr = 32'h500;
    tick();
    a_req = 1'b0;
    tick();
    chk("wd_back", 32'(b_ack), 32'd1);
    b_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dec_re || dec_we || a_ack || busy) acks++;
    end
    chk("wd_quiet", 32'(acks), 32'd0);
    chk("wd_grant_hold", 32'(grant_b), 32'd1);

    chk("exclusive", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
